mdu_issue_ctrl: RTL and testbench

//  Initiator/sequencer for the HI/LO multiply-divide unit. Accepts one MDU op at a time from decode
//  (MULT, DIV, MFHI, MFLO, MTHI, MTLO), drives the unit's MUL_* port, and waits for MUL_Flag.

---
 rtl/mdu_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller between the ID/EX stage and the HI/LO multiply-divide unit.
// Optional build macro MDU_DIV0_TRAP_EN: DIV with a zero divisor is trapped (Err) instead of issued.
module mdu_issue_ctrl #(
  parameter int SETTLE_CYC = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Op_Valid,
  output logic        Op_Ready,
  input  logic [2:0]  Op_Code,
  input  logic [31:0] Op_RS,
  input  logic [31:0] Op_RT,
  output logic        Rd_Valid,
  output logic [31:0] Rd_Data,
  output logic        Done,
  output logic        Err,
  output logic        MUL_Start,
  output logic [1:0]  MUL_SelMD,
  output logic        MUL_SelHL,
  output logic        MUL_Write,
  output logic [31:0] MUL_DA,
  output logic [31:0] MUL_DB,
  input  logic        MUL_Flag,
  input  logic [31:0] MUL_DC
);

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MFHI = 3'd2;
  localparam logic [2:0] OP_MFLO = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  // One counter serves both WAIT (timeout) and SETTLE; SETTLE_CYC <= 15 always fits in 4 bits.
  localparam int            CW          = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_WRITE, S_READ, S_CAPTURE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          accept, div_zero, timeout_hit;
  logic          start_nxt, write_nxt, done_nxt, err_nxt, rd_valid_nxt, selhl_nxt;
  logic [1:0]    selmd_nxt;
  logic [31:0]   da_nxt, db_nxt, rd_data_nxt;

  always_comb begin
    accept = Op_Valid & Op_Ready;
`ifdef MDU_DIV0_TRAP_EN
    div_zero = (Op_Code == OP_DIV) && (Op_RT == 32'd0);
`else
    div_zero = 1'b0;
`endif
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_VAL);

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    start_nxt    = 1'b0;
    write_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    rd_valid_nxt = 1'b0;
    selmd_nxt    = MUL_SelMD;
    selhl_nxt    = MUL_SelHL;
    da_nxt       = MUL_DA;
    db_nxt       = MUL_DB;
    rd_data_nxt  = Rd_Data;

    // Outputs are registered from the next state, so each pulse lines up with the state it belongs to.
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (Op_Code)
            OP_MULT, OP_DIV: begin
              if (div_zero) begin
                err_nxt = 1'b1;
              end else begin
                state_nxt = S_ISSUE;
                start_nxt = 1'b1;
                selmd_nxt = {1'b0, Op_Code[0]};
                da_nxt    = Op_RS;
                db_nxt    = Op_RT;
              end
            end
            OP_MFHI, OP_MFLO: begin
              state_nxt = S_READ;
              selhl_nxt = (Op_Code == OP_MFHI);
            end
            OP_MTHI, OP_MTLO: begin
              state_nxt = S_WRITE;
              write_nxt = 1'b1;
              selhl_nxt = (Op_Code == OP_MTHI);
              db_nxt    = Op_RS;
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      // A flag left high by the previous op is only visible during ISSUE, which never samples it.
      S_ISSUE: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        if (MUL_Flag) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_WRITE: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      S_READ:  state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        state_nxt    = S_IDLE;
        rd_valid_nxt = 1'b1;
        rd_data_nxt  = MUL_DC;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      Op_Ready  <= 1'b1;
      MUL_Start <= 1'b0;
      MUL_Write <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      Rd_Valid  <= 1'b0;
      MUL_SelMD <= 2'b00;
      MUL_SelHL <= 1'b0;
      MUL_DA    <= '0;
      MUL_DB    <= '0;
      Rd_Data   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Op_Ready  <= (state_nxt == S_IDLE);
      MUL_Start <= start_nxt;
      MUL_Write <= write_nxt;
      Done      <= done_nxt;
      Err       <= err_nxt;
      Rd_Valid  <= rd_valid_nxt;
      MUL_SelMD <= selmd_nxt;
      MUL_SelHL <= selhl_nxt;
      MUL_DA    <= da_nxt;
      MUL_DB    <= db_nxt;
      Rd_Data   <= rd_data_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: a behavioural HI/LO unit plus a scoreboard of
// expected Done/Err/Rd_Valid events, each tagged with the cycle it must appear in.
module tb_mdu_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Op_Valid = 1'b0;
  logic [2:0]  Op_Code = 3'd0;
  logic [31:0] Op_RS = '0;
  logic [31:0] Op_RT = '0;
  logic        Op_Ready, Rd_Valid, Done, Err, MUL_Start, MUL_SelHL, MUL_Write, MUL_Flag;
  logic [31:0] Rd_Data, MUL_DA, MUL_DB, MUL_DC;
  logic [1:0]  MUL_SelMD;

  mdu_issue_ctrl #(.SETTLE_CYC(1), .TIMEOUT(64)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Op_Valid(Op_Valid), .Op_Ready(Op_Ready),
    .Op_Code(Op_Code), .Op_RS(Op_RS), .Op_RT(Op_RT), .Rd_Valid(Rd_Valid),
    .Rd_Data(Rd_Data), .Done(Done), .Err(Err), .MUL_Start(MUL_Start),
    .MUL_SelMD(MUL_SelMD), .MUL_SelHL(MUL_SelHL), .MUL_Write(MUL_Write),
    .MUL_DA(MUL_DA), .MUL_DB(MUL_DB), .MUL_Flag(MUL_Flag), .MUL_DC(MUL_DC)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int write_cnt = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (MUL_Start) start_cnt <= start_cnt + 1;
    if (MUL_Write) write_cnt <= write_cnt + 1;
  end

  // Behavioural multiply-divide unit: flag drops on Start and rises flag_delay cycles later (0 = never).
  int          flag_delay = 1;
  int          countdown = 0;
  logic        flag = 1'b0;
  logic [31:0] hi = '0, lo = '0, pend_hi = '0, pend_lo = '0;

  function automatic logic [63:0] unit_result(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b);
    if (md == 2'b00) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0)  return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  always @(posedge Clk) begin
    if (MUL_Start) begin
      countdown <= flag_delay - 1;
      if (flag_delay == 1) begin
        flag <= 1'b1;
        {hi, lo} <= unit_result(MUL_SelMD, MUL_DA, MUL_DB);
      end else begin
        flag <= 1'b0;
        {pend_hi, pend_lo} <= unit_result(MUL_SelMD, MUL_DA, MUL_DB);
      end
    end else if (countdown > 0) begin
      countdown <= countdown - 1;
      if (countdown == 1) begin
        flag <= 1'b1;
        hi   <= pend_hi;
        lo   <= pend_lo;
      end
    end
    if (MUL_Write) begin
      if (MUL_SelHL) hi <= MUL_DB;
      else           lo <= MUL_DB;
    end
  end

  assign MUL_Flag = flag;
  assign MUL_DC   = flag ? (MUL_SelHL ? hi : lo) : 32'd0;

  typedef enum {EV_NONE, EV_DONE, EV_ERR, EV_RD} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] data;
    int          at_cyc;
  } ev_t;

  ev_t exp_q[$];

  // Scoreboard: every pulse must match the oldest expectation in kind, cycle and (for reads) data.
  always @(negedge Clk) begin
    ev_kind_t k;
    ev_t      e;
    if (Reset_n && (Done || Err || Rd_Valid)) begin
      checks++;
      k = Done ? EV_DONE : (Err ? EV_ERR : EV_RD);
      if ((32'(Done) + 32'(Err) + 32'(Rd_Valid)) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: Done=%b Err=%b Rd_Valid=%b at cycle %0d, required at most one", Done, Err, Rd_Valid, cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: %s at cycle %0d, required no event", k.name(), cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.at_cyc != cyc || (k == EV_RD && Rd_Data !== e.data)) begin
          errors++;
          $display("FAIL event: got %s cycle %0d data %h, required %s cycle %0d data %h",
                   k.name(), cyc, Rd_Data, e.kind.name(), e.at_cyc, e.data);
        end
      end
    end
  end

  // Called at a negedge; holds Op_Valid until accepted, returns at the negedge one cycle after acceptance.
  task automatic send_op(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                         input ev_kind_t kind, input logic [31:0] data, input int lat, output int base);
    int waited = 0;
    Op_Valid = 1'b1;
    Op_Code  = code;
    Op_RS    = rs;
    Op_RT    = rt;
    while (Op_Ready !== 1'b1 && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    base = cyc;
    checks++;
    if (Op_Ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: Op_Ready=%b after %0d cycles, required 1", Op_Ready, waited);
      Op_Valid = 1'b0;
      return;
    end
    if (kind != EV_NONE) exp_q.push_back(ev_t'{kind, data, base + lat});
    @(negedge Clk);
    Op_Valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (Op_Ready !== 1'b1 || {Done, Err, Rd_Valid, MUL_Start, MUL_Write, MUL_SelMD, MUL_SelHL, MUL_DA, MUL_DB, Rd_Data} !== '0) begin
      errors++;
      $display("FAIL reset_state: Op_Ready=%b pulses=%b%b%b%b%b DA=%h DB=%h Rd=%h, required ready=1 all others 0",
               Op_Ready, Done, Err, Rd_Valid, MUL_Start, MUL_Write, MUL_DA, MUL_DB, Rd_Data);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_mult_mflo();
    int base;
    flag_delay = 1;
    send_op(3'd0, 32'd7, 32'd6, EV_DONE, 32'd0, 4, base);
    checks++;
    if ({MUL_Start, MUL_SelMD, MUL_DA, MUL_DB, Op_Ready} !== {1'b1, 2'b00, 32'd7, 32'd6, 1'b0}) begin
      errors++;
      $display("FAIL mult_issue: Start=%b SelMD=%b DA=%0d DB=%0d Ready=%b, required 1 00 7 6 0",
               MUL_Start, MUL_SelMD, MUL_DA, MUL_DB, Op_Ready);
    end
    @(negedge Clk);
    checks++;
    if (MUL_Start !== 1'b0) begin
      errors++;
      $display("FAIL mult_start_width: Start=%b one cycle later, required 0", MUL_Start);
    end
    drain("mult_done", 20);
    send_op(3'd3, 32'd0, 32'd0, EV_RD, 32'd42, 3, base);
    checks++;
    if (MUL_SelHL !== 1'b0) begin
      errors++;
      $display("FAIL mflo_selhl: SelHL=%b, required 0", MUL_SelHL);
    end
    drain("mflo_read", 20);
    checks++;
    if (Rd_Data !== 32'd42 || Rd_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: Rd_Data=%0d Rd_Valid=%b, required 42 0", Rd_Data, Rd_Valid);
    end
  endtask

  // Flag arrives two cycles later than the fastest case and is still high from MULT during ISSUE.
  task automatic test_div_mfhi();
    int base;
    flag_delay = 3;
    send_op(3'd1, 32'd100, 32'd7, EV_DONE, 32'd0, 6, base);
    checks++;
    if ({MUL_Start, MUL_SelMD, MUL_DA, MUL_DB} !== {1'b1, 2'b01, 32'd100, 32'd7}) begin
      errors++;
      $display("FAIL div_issue: Start=%b SelMD=%b DA=%0d DB=%0d, required 1 01 100 7", MUL_Start, MUL_SelMD, MUL_DA, MUL_DB);
    end
    drain("div_done", 20);
    send_op(3'd2, 32'd0, 32'd0, EV_RD, 32'd2, 3, base);
    checks++;
    if (MUL_SelHL !== 1'b1) begin
      errors++;
      $display("FAIL mfhi_selhl: SelHL=%b, required 1", MUL_SelHL);
    end
    drain("mfhi_read", 20);
  endtask

  task automatic test_back_to_back();
    int b1, b2, b3, b4;
    send_op(3'd4, 32'hDEADBEEF, 32'd0, EV_DONE, 32'd0, 2, b1);
    checks++;
    if ({MUL_Write, MUL_SelHL, MUL_DB, Op_Ready} !== {1'b1, 1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL mthi_write: Write=%b SelHL=%b DB=%h Ready=%b, required 1 1 deadbeef 0", MUL_Write, MUL_SelHL, MUL_DB, Op_Ready);
    end
    send_op(3'd2, 32'd0, 32'd0, EV_RD, 32'hDEADBEEF, 3, b2);
    checks++;
    if (b2 != b1 + 2) begin
      errors++;
      $display("FAIL mthi_ready: next accept at accept+%0d, required accept+2", b2 - b1);
    end
    send_op(3'd5, 32'h0000_1234, 32'd0, EV_DONE, 32'd0, 2, b3);
    checks++;
    if ({MUL_Write, MUL_SelHL, MUL_DB} !== {1'b1, 1'b0, 32'h0000_1234}) begin
      errors++;
      $display("FAIL mtlo_write: Write=%b SelHL=%b DB=%h, required 1 0 00001234", MUL_Write, MUL_SelHL, MUL_DB);
    end
    send_op(3'd3, 32'd0, 32'd0, EV_RD, 32'h0000_1234, 3, b4);
    checks++;
    if (b3 != b2 + 3 || b4 != b3 + 2) begin
      errors++;
      $display("FAIL b2b_spacing: gaps %0d %0d, required 3 2", b3 - b2, b4 - b3);
    end
    drain("back_to_back", 20);
  endtask

  task automatic test_timeout();
    int base, starts;
    flag_delay = 0;
    starts = start_cnt;
    send_op(3'd0, 32'd3, 32'd5, EV_ERR, 32'd0, 66, base);
    drain("timeout_err", 100);
    checks++;
    if (Op_Ready !== 1'b1 || start_cnt != starts + 1) begin
      errors++;
      $display("FAIL timeout_recover: Ready=%b starts=%0d, required 1 %0d", Op_Ready, start_cnt - starts, 1);
    end
  endtask

  task automatic test_div_zero();
    int base, starts;
    flag_delay = 1;
    starts = start_cnt;
`ifdef MDU_DIV0_TRAP_EN
    send_op(3'd1, 32'd9, 32'd0, EV_ERR, 32'd0, 1, base);
    drain("div0_trap", 20);
    checks++;
    if (start_cnt != starts) begin
      errors++;
      $display("FAIL div0_no_start: %0d starts, required 0", start_cnt - starts);
    end
`else
    send_op(3'd1, 32'd9, 32'd0, EV_DONE, 32'd0, 4, base);
    drain("div0_issue", 20);
    checks++;
    if (start_cnt != starts + 1) begin
      errors++;
      $display("FAIL div0_start: %0d starts, required 1", start_cnt - starts);
    end
`endif
  endtask

  task automatic test_illegal();
    int base, starts, writes;
    logic [31:0] da, db;
    starts = start_cnt;
    writes = write_cnt;
    da = MUL_DA;
    db = MUL_DB;
    send_op(3'd6, 32'h1111_1111, 32'h2222_2222, EV_ERR, 32'd0, 1, base);
    checks++;
    if (Op_Ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ready: Op_Ready=%b, required 1", Op_Ready);
    end
    send_op(3'd7, 32'h3333_3333, 32'h4444_4444, EV_ERR, 32'd0, 1, base);
    drain("illegal_err", 20);
    checks++;
    if (start_cnt != starts || write_cnt != writes || MUL_DA !== da || MUL_DB !== db) begin
      errors++;
      $display("FAIL illegal_quiet: starts=%0d writes=%0d DA=%h DB=%h, required 0 0 %h %h",
               start_cnt - starts, write_cnt - writes, MUL_DA, MUL_DB, da, db);
    end
  endtask

  task automatic test_reset_mid_op();
    int base;
    flag_delay = 0;
    send_op(3'd0, 32'd1, 32'd1, EV_NONE, 32'd0, 0, base);
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++;
    if (Op_Ready !== 1'b1 || {Done, Err, Rd_Valid, MUL_Start, MUL_Write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_op: Ready=%b Done=%b Err=%b Rd_Valid=%b Start=%b Write=%b, required 1 0 0 0 0 0",
               Op_Ready, Done, Err, Rd_Valid, MUL_Start, MUL_Write);
    end
    Reset_n = 1'b1;
    repeat (80) @(negedge Clk);
    checks++;
    if (Op_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle: Op_Ready=%b long after reset, required 1", Op_Ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge Clk);
    test_reset();
    test_mult_mflo();
    test_div_mfhi();
    test_back_to_back();
    test_timeout();
    test_div_zero();
    test_illegal();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
